// File: rtl/keypad_clock_core_if.sv
// ---------------------------------------------------------------------------
// keypad_clock_core_if
// Bundles the board-facing signals of keypad_clock_core.
//   set_mode  : DIP switch level, 1 = set mode, 0 = run mode
//   keypad    : one-hot digit keys, bit n = digit n, all-zero = no key
//   seg_data  : segment pattern for the digit currently enabled, 0 = blank
//   seg_com   : active-low digit enables
//   time_bcd  : committed time {h_ten,h_one,m_ten,m_one,s_ten,s_one}
//   tick_1s   : one-cycle pulse on each second increment
//   set_done  : one-cycle pulse when an edit commits
//   key_err   : one-cycle pulse when a key is rejected
// master drives the inputs (board / bench), slave is the clock core.
// ---------------------------------------------------------------------------
interface keypad_clock_core_if;
    logic        set_mode;
    logic [9:0]  keypad;
    logic [7:0]  seg_data;
    logic [7:0]  seg_com;
    logic [23:0] time_bcd;
    logic        tick_1s;
    logic        set_done;
    logic        key_err;

    modport master (
        output set_mode,
        output keypad,
        input  seg_data,
        input  seg_com,
        input  time_bcd,
        input  tick_1s,
        input  set_done,
        input  key_err
    );

    modport slave (
        input  set_mode,
        input  keypad,
        output seg_data,
        output seg_com,
        output time_bcd,
        output tick_1s,
        output set_done,
        output key_err
    );
endinterface

// File: rtl/keypad_clock_core.sv
// ---------------------------------------------------------------------------
// keypad_clock_core
// Running HH:MM:SS clock with keypad time-set and a multiplexed 6-digit
// 7-segment scan. Time advances once per CLK_HZ cycles in run mode. In set
// mode a shadow buffer is edited digit by digit with per-position range
// checks; the sixth valid digit commits the buffer into the running time.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : keypad_clock_core_if.slave (set_mode, keypad in; display, time
//          and status pulses out)
// Parameters:
//   CLK_HZ    : clk cycles per second
//   SCAN_DIV  : clk cycles each display slot is held (>=1)
//   BLINK_DIV : clk cycles per blink half-period in set mode (>=1)
//   MODE_12H  : 0 = 00..23 hours, 1 = 01..12 hours
// ---------------------------------------------------------------------------
module keypad_clock_core #(
    parameter int CLK_HZ    = 1000,
    parameter int SCAN_DIV  = 1,
    parameter int BLINK_DIV = 250,
    parameter bit MODE_12H  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    keypad_clock_core_if.slave  bus
);

    localparam int PW = (CLK_HZ > 1)    ? $clog2(CLK_HZ)    : 1;
    localparam int SW = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TERM = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SCAN_TERM  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_TERM = BW'(BLINK_DIV - 1);
    localparam logic [23:0]   RESET_TIME = MODE_12H ? 24'h120000 : 24'h000000;

    // ---------------------------------------------------------------- helpers
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] key_encode(input logic [9:0] k);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (k[i]) begin
                d = 4'(i);
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    // Range check of a candidate digit at a cursor position; h_ten is the
    // buffer's hour-tens digit, already written earlier in the same edit.
    function automatic logic digit_ok(input logic [2:0] pos, input logic [3:0] d,
                                      input logic [3:0] h_ten);
        logic ok;
        case (pos)
            3'd0: ok = MODE_12H ? (d <= 4'd1) : (d <= 4'd2);
            3'd1: begin
                if (MODE_12H) begin
                    if (h_ten == 4'd0) begin
                        ok = (d >= 4'd1) && (d <= 4'd9);
                    end else begin
                        ok = (d <= 4'd2);
                    end
                end else begin
                    if (h_ten == 4'd2) begin
                        ok = (d <= 4'd3);
                    end else begin
                        ok = (d <= 4'd9);
                    end
                end
            end
            3'd2:    ok = (d <= 4'd5);
            3'd3:    ok = (d <= 4'd9);
            3'd4:    ok = (d <= 4'd5);
            3'd5:    ok = (d <= 4'd9);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] hour_inc(input logic [3:0] ht, input logic [3:0] ho);
        logic [7:0] r;
        if (MODE_12H && (ht == 4'd1) && (ho == 4'd2)) begin
            r = 8'h01;
        end else if (!MODE_12H && (ht == 4'd2) && (ho == 4'd3)) begin
            r = 8'h00;
        end else if (ho == 4'd9) begin
            r = {ht + 4'd1, 4'd0};
        end else begin
            r = {ht, ho + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [23:0] time_inc(input logic [23:0] t);
        logic [3:0] ht, ho, mt, mo, st, so;
        {ht, ho, mt, mo, st, so} = t;
        if (so != 4'd9) begin
            so = so + 4'd1;
        end else begin
            so = 4'd0;
            if (st != 4'd5) begin
                st = st + 4'd1;
            end else begin
                st = 4'd0;
                if (mo != 4'd9) begin
                    mo = mo + 4'd1;
                end else begin
                    mo = 4'd0;
                    if (mt != 4'd5) begin
                        mt = mt + 4'd1;
                    end else begin
                        mt = 4'd0;
                        {ht, ho} = hour_inc(ht, ho);
                    end
                end
            end
        end
        return {ht, ho, mt, mo, st, so};
    endfunction

    // ---------------------------------------------------------------- state
    logic [23:0]   time_r;
    logic [23:0]   buf_r;
    logic [2:0]    cursor_r;
    logic [PW-1:0] presc_r;
    logic          set_prev_r;
    logic [9:0]    keypad_prev_r;
    logic          set_done_r;
    logic          key_err_r;
    logic [SW-1:0] scan_cnt_r;
    logic [2:0]    slot_r;
    logic [BW-1:0] blink_cnt_r;
    logic          blink_off_r;
    logic [7:0]    seg_com_r;
    logic [7:0]    seg_data_r;

    logic          set_entry_s;
    logic          set_exit_s;
    logic          run_s;
    logic          tick_s;
    logic          one_hot_s;
    logic          key_evt_s;
    logic [3:0]    key_digit_s;
    logic          key_ok_s;
    logic [23:0]   buf_next_s;
    logic [23:0]   disp_src_s;
    logic [3:0]    slot_digit_s;
    logic [7:0]    com_next_s;
    logic [7:0]    data_next_s;

    // Mode transitions, tick and keypad event qualification.
    always_comb begin
        set_entry_s = bus.set_mode && !set_prev_r;
        set_exit_s  = !bus.set_mode && set_prev_r;
        // Run only when set_mode is low in both cycles, so the exit cycle
        // (prescaler restart) never ticks.
        run_s       = !bus.set_mode && !set_prev_r;
        tick_s      = run_s && (presc_r == PRESC_TERM);
        one_hot_s   = (bus.keypad != 10'd0) &&
                      ((bus.keypad & (bus.keypad - 10'd1)) == 10'd0);
        key_evt_s   = one_hot_s && (keypad_prev_r == 10'd0) &&
                      bus.set_mode && set_prev_r;
        key_digit_s = key_encode(bus.keypad);
        key_ok_s    = digit_ok(cursor_r, key_digit_s, buf_r[23:20]);
    end

    // Buffer with the keyed digit written at the cursor position.
    always_comb begin
        buf_next_s = buf_r;
        case (cursor_r)
            3'd0:    buf_next_s[23:20] = key_digit_s;
            3'd1:    buf_next_s[19:16] = key_digit_s;
            3'd2:    buf_next_s[15:12] = key_digit_s;
            3'd3:    buf_next_s[11:8]  = key_digit_s;
            3'd4:    buf_next_s[7:4]   = key_digit_s;
            3'd5:    buf_next_s[3:0]   = key_digit_s;
            default: buf_next_s = buf_r;
        endcase
    end

    // Timekeeping, set-mode editing and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_r        <= RESET_TIME;
            buf_r         <= RESET_TIME;
            cursor_r      <= 3'd0;
            presc_r       <= '0;
            set_prev_r    <= 1'b0;
            keypad_prev_r <= 10'd0;
            set_done_r    <= 1'b0;
            key_err_r     <= 1'b0;
        end else begin
            set_prev_r    <= bus.set_mode;
            keypad_prev_r <= bus.keypad;
            set_done_r    <= 1'b0;
            key_err_r     <= 1'b0;
            if (set_entry_s) begin
                buf_r    <= time_r;
                cursor_r <= 3'd0;
                presc_r  <= '0;
            end else if (set_exit_s) begin
                // Any partial edit is simply abandoned; time stays frozen.
                cursor_r <= 3'd0;
                presc_r  <= '0;
            end else if (key_evt_s) begin
                if (key_ok_s) begin
                    buf_r <= buf_next_s;
                    if (cursor_r == 3'd5) begin
                        time_r     <= buf_next_s;
                        set_done_r <= 1'b1;
                        cursor_r   <= 3'd0;
                        presc_r    <= '0;
                    end else begin
                        cursor_r <= cursor_r + 3'd1;
                    end
                end else begin
                    key_err_r <= 1'b1;
                end
            end else if (run_s) begin
                if (tick_s) begin
                    presc_r <= '0;
                    time_r  <= time_inc(time_r);
                end else begin
                    presc_r <= presc_r + PW'(1);
                end
            end else begin
                presc_r <= presc_r;
            end
        end
    end

    // Display slot sequencing and set-mode blink phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_r  <= '0;
            slot_r      <= 3'd0;
            blink_cnt_r <= '0;
            blink_off_r <= 1'b0;
        end else begin
            if (scan_cnt_r == SCAN_TERM) begin
                scan_cnt_r <= '0;
                slot_r     <= slot_r + 3'd1;
            end else begin
                scan_cnt_r <= scan_cnt_r + SW'(1);
            end
            if (set_entry_s || !set_prev_r) begin
                blink_cnt_r <= '0;
                blink_off_r <= 1'b0;
            end else if (blink_cnt_r == BLINK_TERM) begin
                blink_cnt_r <= '0;
                blink_off_r <= !blink_off_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BW'(1);
            end
        end
    end

    // Digit selection and segment pattern for the current slot.
    always_comb begin
        disp_src_s = set_prev_r ? buf_r : time_r;
        case (slot_r)
            3'd0:    slot_digit_s = disp_src_s[23:20];
            3'd1:    slot_digit_s = disp_src_s[19:16];
            3'd2:    slot_digit_s = disp_src_s[15:12];
            3'd3:    slot_digit_s = disp_src_s[11:8];
            3'd4:    slot_digit_s = disp_src_s[7:4];
            3'd5:    slot_digit_s = disp_src_s[3:0];
            default: slot_digit_s = 4'd0;
        endcase
        if (slot_r <= 3'd5) begin
            com_next_s = ~(8'h80 >> slot_r);
            if (set_prev_r && blink_off_r && (slot_r == cursor_r)) begin
                data_next_s = 8'h00;
            end else begin
                data_next_s = seg_decode(slot_digit_s);
            end
        end else begin
            com_next_s  = 8'hFF;
            data_next_s = 8'h00;
        end
    end

    // Registered display pins, one cycle behind the slot counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_com_r  <= 8'hFF;
            seg_data_r <= 8'h00;
        end else begin
            seg_com_r  <= com_next_s;
            seg_data_r <= data_next_s;
        end
    end

    assign bus.seg_com  = seg_com_r;
    assign bus.seg_data = seg_data_r;
    assign bus.time_bcd = time_r;
    // tick_1s is high during the terminal prescaler cycle; time_bcd follows
    // on the next cycle.
    assign bus.tick_1s  = tick_s;
    assign bus.set_done = set_done_r;
    assign bus.key_err  = key_err_r;

endmodule
